// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit handshake bundle: hazard inputs from the EX/MEM/WB stages and
// stall/flush/forward controls back to the pipeline registers and M-unit.
interface hazard_stall_ctrl_if;
  logic [4:0] RsE;
  logic [4:0] RtE;
  logic [4:0] WriteRegM;
  logic [4:0] WriteRegW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       MemtoRegM;
  logic       BranchTakenE;
  logic       MdOpE;
  logic       MdDoneE;

  logic       PCEnF;
  logic       EnIF_ID;
  logic       EnID_EX;
  logic       ClrIF_ID;
  logic       ClrEX_MEM;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MdStartE;
  logic       MdErr;

  // The hazard controller is the controlling side of the EN/CLR bundle.
  modport master (
    input  RsE, RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW,
           MemtoRegM, BranchTakenE, MdOpE, MdDoneE,
    output PCEnF, EnIF_ID, EnID_EX, ClrIF_ID, ClrEX_MEM,
           ForwardAE, ForwardBE, MdStartE, MdErr
  );

  modport slave (
    output RsE, RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW,
           MemtoRegM, BranchTakenE, MdOpE, MdDoneE,
    input  PCEnF, EnIF_ID, EnID_EX, ClrIF_ID, ClrEX_MEM,
           ForwardAE, ForwardBE, MdStartE, MdErr
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32IM pipeline, with M-op
// sequencing and watchdog. Define HAZ_PERF_CNT_EN to add saturating perf counters.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic                CLK,
  input  logic                RST,
  hazard_stall_ctrl_if.master hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]         StallCnt,
  output logic [31:0]         FlushCnt,
  output logic [15:0]         MdAbortCnt
`endif
);

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_ABORT
  } md_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_t        state;
  logic [CNT_W-1:0] md_cnt;
  logic             kill_e;
  logic             rst_q;

  logic             in_reset;
  logic             load_use;
  logic             start_md;
  logic             md_wait;
  logic             stall_e;
  logic             branch_acc;

  // Outputs stay forced for the cycle after RST drops so the pipeline
  // registers see one full clean flush before the first real instruction.
  assign in_reset = RST | rst_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RsE)
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RsE)
      hz.ForwardAE = 2'b01;

    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RtE)
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RtE)
      hz.ForwardBE = 2'b01;
  end

  always_comb begin
    load_use   = hz.MemtoRegM && hz.RegWriteM && hz.WriteRegM != 5'd0 &&
                 (hz.WriteRegM == hz.RsE || hz.WriteRegM == hz.RtE);
    // An M-op cannot launch while its operands still wait on a load.
    start_md   = !in_reset && state == MD_IDLE && hz.MdOpE && !kill_e && !load_use;
    md_wait    = state == MD_BUSY && !hz.MdDoneE;
    stall_e    = !in_reset && !kill_e && (load_use || start_md || md_wait);
    branch_acc = !in_reset && hz.BranchTakenE && !stall_e && !kill_e;

    hz.PCEnF     = 1'b1;
    hz.EnIF_ID   = 1'b1;
    hz.EnID_EX   = 1'b1;
    hz.ClrIF_ID  = 1'b1;
    hz.ClrEX_MEM = 1'b1;
    hz.MdStartE  = 1'b0;
    hz.MdErr     = 1'b0;
    if (!in_reset) begin
      hz.PCEnF     = !stall_e;
      hz.EnIF_ID   = !stall_e;
      hz.EnID_EX   = !stall_e;
      hz.ClrIF_ID  = branch_acc;
      hz.ClrEX_MEM = kill_e || load_use || start_md || md_wait || state == MD_ABORT;
      hz.MdStartE  = start_md;
      hz.MdErr     = state == MD_ABORT;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    rst_q <= RST;
    if (in_reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
      kill_e <= 1'b0;
    end else begin
      kill_e <= branch_acc;
      case (state)
        MD_IDLE: begin
          if (start_md) begin
            state  <= MD_BUSY;
            md_cnt <= '0;
          end
        end
        MD_BUSY: begin
          if (hz.MdDoneE)
            state <= MD_IDLE;
          else if (md_cnt == CNT_LAST)
            state <= MD_ABORT;
          else
            md_cnt <= md_cnt + 1'b1;
        end
        MD_ABORT: state <= MD_IDLE;
        default:  state <= MD_IDLE;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (in_reset) begin
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MdAbortCnt <= '0;
    end else begin
      if (stall_e && StallCnt != '1)
        StallCnt <= StallCnt + 1'b1;
      if (branch_acc && FlushCnt != '1)
        FlushCnt <= FlushCnt + 1'b1;
      if (state == MD_ABORT && MdAbortCnt != '1)
        MdAbortCnt <= MdAbortCnt + 1'b1;
    end
  end
`endif

endmodule
